// File: rtl/aes_stream_cifra.sv
// Streaming AES-128 encryption front end: assembles byte beats into 128-bit blocks,
// pads the tail, runs each block through cifraBloco (ECB or CBC) and emits ciphertext.
module aes_stream_cifra #(
   parameter int         IN_BYTES  = 4,
   parameter logic [7:0] PAD_BYTE  = 8'hFF,
   parameter bit         BYTE_SWAP = 1'b1,
   parameter int         CORE_LAT  = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [127:0]                key,
   input  logic [127:0]                iv,
   input  logic                        mode_cbc,
   input  logic                        key_load,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [8*IN_BYTES-1:0]       in_data,
   input  logic                        in_last,
   input  logic [$clog2(IN_BYTES):0]   in_bytes,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [127:0]                out_data,
   output logic                        out_last,
   output logic                        busy
);

   typedef enum logic [1:0] {FILL, CIPHER, OUT} state_t;

   state_t         state, state_nx;
   logic [4:0]     cnt, nb, sum;
   logic [3:0]     wcnt;
   logic           run, ld_r, cbc_r, last_r;
   logic [127:0]   key_r, chain, blk, blk_nx, op_r, res, ibw;
   logic           acc, go, empty, kl_ok, cap;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254 by repeated squaring) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq, v;
      sq = a;
      v  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         v  = gmul(v, sq);
      end
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] inverte(input logic [127:0] b);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = b[127-8*i -: 8];
      return r;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic mix);
      logic [127:0] t;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      if (mix) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[127-32*c -: 8];
            a1 = t[119-32*c -: 8];
            a2 = t[111-32*c -: 8];
            a3 = t[103-32*c -: 8];
            t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
         end
      end
      return t;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
      logic [127:0] s, rk;
      logic [7:0]   rc;
      s  = pt ^ k;
      rk = k;
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         s  = aes_round(s, r != 10);
         rk = next_key(rk, rc);
         rc = xt(rc);
         s  = s ^ rk;
      end
      return s;
   endfunction

   // cifraBloco works on byte-reversed blocks (byte 0 in the LSBs)
   function automatic logic [127:0] cifra_bloco(input logic [127:0] x, input logic [127:0] k);
      return inverte(aes_enc(inverte(x), inverte(k)));
   endfunction

   assign in_ready = run && (state == FILL);
   assign busy     = (state != FILL) || (cnt != 5'd0);
   assign acc      = in_valid && in_ready;
   assign nb       = in_last ? 5'(in_bytes) : 5'(IN_BYTES);
   assign sum      = cnt + nb;
   assign go       = acc && ((sum == 5'd16) || (in_last && sum != 5'd0));
   assign empty    = acc && in_last && (sum == 5'd0);
   assign kl_ok    = key_load && (state == FILL) && (cnt == 5'd0);
   assign cap      = (state == CIPHER) && ld_r && (wcnt == 4'(CORE_LAT - 1));
   assign ibw      = 128'(in_data) << (128 - 8*IN_BYTES);

   // Beat bytes land after the current fill point; the tail is padded on the closing beat
   always_comb begin
      blk_nx = blk;
      for (int i = 0; i < 16; i++) begin
         if (i >= int'(cnt) && i < int'(sum))
            blk_nx[127-8*i -: 8] = ibw[127-8*(i-int'(cnt)) -: 8];
         else if (i >= int'(sum) && go)
            blk_nx[127-8*i -: 8] = PAD_BYTE;
      end
   end

   always_comb begin
      if (BYTE_SWAP) res = inverte(cifra_bloco(inverte(op_r), inverte(key_r)));
      else           res = cifra_bloco(op_r, key_r);
   end

   always_comb begin
      state_nx = state;
      case (state)
         FILL:    if (go) state_nx = CIPHER;
         CIPHER:  if (cap) state_nx = OUT;
         OUT:     if (out_ready) state_nx = FILL;
         default: state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         run       <= 1'b0;
         cnt       <= 5'd0;
         wcnt      <= 4'd0;
         ld_r      <= 1'b0;
         last_r    <= 1'b0;
         key_r     <= 128'd0;
         chain     <= 128'd0;
         cbc_r     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 128'd0;
         out_last  <= 1'b0;
      end else begin
         state <= state_nx;
         run   <= 1'b1;
         if (kl_ok) begin
            key_r <= key;
            cbc_r <= mode_cbc;
         end
         if (kl_ok || empty)
            chain <= iv;
         else if (state == OUT && out_ready)
            chain <= out_last ? iv : (cbc_r ? out_data : chain);
         if (acc)
            cnt <= sum;
         else if (state == OUT && out_ready)
            cnt <= 5'd0;
         if (go) last_r <= in_last;
         ld_r <= (state == CIPHER);
         wcnt <= (state == CIPHER && ld_r) ? wcnt + 4'd1 : 4'd0;
         if (cap) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_last  <= last_r;
         end else if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Block assembly and core operand: pure data, no reset needed
   always_ff @(posedge clk) begin
      if (acc) blk <= blk_nx;
      if (state == CIPHER && !ld_r) op_r <= blk ^ (cbc_r ? chain : 128'd0);
   end

endmodule
